// File: rtl/conv_encoder_pkg.sv
// conv_encoder_pkg: code constants, FSM encoding and parity helper shared by the
// encoder and the decoder BMU/ACS stages.
package conv_encoder_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational rate-1/2 trellis step, {din, s} -> {pair, next_s}.
module conv_enc_core
  import conv_encoder_pkg::*;
#(
  parameter int             K_W  = conv_encoder_pkg::K,
  parameter logic [K_W-1:0] G0_P = conv_encoder_pkg::G0,
  parameter logic [K_W-1:0] G1_P = conv_encoder_pkg::G1
) (
  input  logic           din,
  input  logic [K_W-2:0] s,
  output logic [1:0]     pair,
  output logic [K_W-2:0] next_s
);
  logic [K_W-1:0] w_reg;
  assign w_reg  = {din, s};
  assign pair   = {parity(32'(w_reg & G0_P)), parity(32'(w_reg & G1_P))};
  assign next_s = w_reg[K_W-1:1];
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 convolutional encoder with zero-tail flush.
// ERR_INJECT_EN adds err_mask/err_stb to flip bits of a loaded pair.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int               K     = conv_encoder_pkg::K,
  parameter logic [K-1:0]     G0    = conv_encoder_pkg::G0,
  parameter logic [K-1:0]     G1    = conv_encoder_pkg::G1,
  parameter int               CNT_W = conv_encoder_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refresh,
  input  logic             din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
`ifdef ERR_INJECT_EN
  input  logic [1:0]       err_mask,
  input  logic             err_stb,
`endif
  output logic [1:0]       bit_pair,
  output logic             pair_valid,
  output logic             pair_tail,
  input  logic             pair_ready,
  output logic [CNT_W-1:0] frame_bits,
  output logic             busy
);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  state_t           r_state;
  logic [K-2:0]     r_s;
  logic [TW-1:0]    r_tail_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frame_bits;
  logic [1:0]       r_pair;
  logic             r_valid;
  logic             r_tail;
  logic             r_en;
  logic             w_out_free;
  logic             w_accept;
  logic             w_tail_issue;
  logic             w_load;
  logic             w_din_bit;
  logic             w_tail_done;
  logic [1:0]       w_code;
  logic [1:0]       w_mask;
  logic [K-2:0]     w_next_s;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_out_free   = !r_valid || pair_ready;
  // r_en keeps din_ready low until the first clock after reset release
  assign din_ready    = r_en && w_out_free && (r_state == ST_IDLE || r_state == ST_DATA) && !refresh;
  assign w_accept     = din_valid && din_ready;
  assign w_tail_issue = (r_state == ST_TAIL) && w_out_free && !refresh;
  assign w_load       = w_accept || w_tail_issue;
  assign w_din_bit    = w_accept && din;
  assign w_tail_done  = r_tail_cnt == TW'(K - 2);
  assign w_cnt_inc    = &r_cnt ? r_cnt : r_cnt + 1'b1;
`ifdef ERR_INJECT_EN
  assign w_mask = err_stb ? err_mask : 2'b00;
`else
  assign w_mask = 2'b00;
`endif

  conv_enc_core #(.K_W(K), .G0_P(G0), .G1_P(G1)) u_core (
    .din    (w_din_bit),
    .s      (r_s),
    .pair   (w_code),
    .next_s (w_next_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_tail_cnt   <= '0;
      r_cnt        <= '0;
      r_frame_bits <= '0;
      r_pair       <= '0;
      r_valid      <= 1'b0;
      r_tail       <= 1'b0;
      r_en         <= 1'b0;
    end else if (refresh) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_tail_cnt   <= '0;
      r_cnt        <= '0;
      r_frame_bits <= '0;
      r_pair       <= '0;
      r_valid      <= 1'b0;
      r_tail       <= 1'b0;
      r_en         <= 1'b1;
    end else begin
      r_en <= 1'b1;
      if (w_load) begin
        r_pair  <= w_code ^ w_mask;
        r_valid <= 1'b1;
        r_tail  <= w_tail_issue;
        r_s     <= w_next_s;
      end else if (pair_ready) begin
        r_valid <= 1'b0;
        r_tail  <= 1'b0;
      end
      if (w_accept) begin
        if (din_last) begin
          r_state      <= ST_TAIL;
          r_frame_bits <= w_cnt_inc;
          r_cnt        <= '0;
          r_tail_cnt   <= '0;
        end else begin
          r_state <= ST_DATA;
          r_cnt   <= w_cnt_inc;
        end
      end else if (w_tail_issue) begin
        r_tail_cnt <= w_tail_done ? '0 : TW'(r_tail_cnt + 1'b1);
        if (w_tail_done) r_state <= ST_IDLE;
      end
    end
  end

  assign bit_pair   = r_pair;
  assign pair_valid = r_valid;
  assign pair_tail  = r_tail;
  assign frame_bits = r_frame_bits;
  assign busy       = r_state != ST_IDLE;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized self-checking bench against a history-based code model.
module tb_conv_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic [1:0]  err_mask = 2'b00;
  logic        err_stb = 1'b0;
  logic [1:0]  bit_pair;
  logic        pair_valid;
  logic        pair_tail;
  logic        pair_ready = 1'b1;
  logic [15:0] frame_bits;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;

  conv_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .refresh    (refresh),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
`ifdef ERR_INJECT_EN
    .err_mask   (err_mask),
    .err_stb    (err_stb),
`endif
    .bit_pair   (bit_pair),
    .pair_valid (pair_valid),
    .pair_tail  (pair_tail),
    .pair_ready (pair_ready),
    .frame_bits (frame_bits),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit bit_at(input bit f[$], input int j);
    return (j >= 0 && j < f.size()) ? f[j] : 1'b0;
  endfunction

  // Expected stream {tail, g0, g1}: g0 = x[j]^x[j-1]^x[j-2], g1 = x[j]^x[j-2], two zero tail bits per frame
  function automatic void model(input bit b[$], input bit l[$], output logic [2:0] ex[$]);
    bit f[$];
    bit x0, x1, x2;
    ex = {};
    f = {};
    foreach (b[i]) begin
      f.push_back(b[i]);
      if (l[i]) begin
        for (int j = 0; j < f.size() + 2; j++) begin
          x0 = bit_at(f, j);
          x1 = bit_at(f, j - 1);
          x2 = bit_at(f, j - 2);
          ex.push_back({j >= f.size(), x0 ^ x1 ^ x2, x0 ^ x2});
        end
        f = {};
      end
    end
  endfunction

  task automatic run_frame(input bit b[$], input bit l[$], input int n_exp, input int rmode,
                           input int vmode, input bit inj, output logic [2:0] got[$],
                           output int unstable, output int gaps, output bit timeout);
    int idx = 0;
    int cyc = 0;
    int last = -1;
    bit stalled = 1'b0;
    logic [1:0] held = 2'b00;
    got = {};
    unstable = 0;
    gaps = 0;
    while ((idx < b.size() || got.size() < n_exp) && cyc < 400) begin
      din_valid  = (idx < b.size()) && (vmode == 0 || $urandom_range(0, 3) != 0);
      din        = (idx < b.size()) ? b[idx] : 1'b0;
      din_last   = (idx < b.size()) ? l[idx] : 1'b0;
      pair_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      err_stb    = inj && idx == 0;
      @(negedge clk);
      if (stalled && (!pair_valid || bit_pair !== held)) unstable++;
      if (din_valid && din_ready) idx++;
      if (pair_valid && pair_ready) begin
        got.push_back({pair_tail, bit_pair});
        if (last >= 0) gaps += cyc - last - 1;
        last = cyc;
      end
      stalled = pair_valid && !pair_ready;
      held = bit_pair;
      @(posedge clk);
      #1;
      cyc++;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    err_stb = 1'b0;
    pair_ready = 1'b1;
    timeout = cyc >= 400;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bit_pair, pair_valid, pair_tail, busy, din_ready, frame_bits} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pair=%b v=%b t=%b busy=%b rdy=%b fb=%0d expected all 0",
               bit_pair, pair_valid, pair_tail, busy, din_ready, frame_bits);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_early: got %b expected 0", din_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_clk: got %b expected 1", din_ready);
    end
  endtask

  task automatic test_spec_frame(input int rmode, input string nm);
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    logic [2:0] ref_seq[$];
    int uns, gaps;
    bit to;
    b = {1'b1, 1'b0, 1'b1, 1'b1};
    l = {1'b0, 1'b0, 1'b0, 1'b1};
    ref_seq = {3'b011, 3'b010, 3'b000, 3'b001, 3'b101, 3'b111};
    run_frame(b, l, 6, rmode, 0, 1'b0, got, uns, gaps, to);
    n_checks++;
    if (to || got.size() != 6) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pairs (timeout=%b) expected 6", nm, got.size(), to);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++;
      if (got[i] !== ref_seq[i]) begin
        n_fail++;
        $display("FAIL %s_pair%0d: got {tail,pair}=%b expected %b", nm, i, got[i], ref_seq[i]);
      end
    end
    n_checks++;
    if (frame_bits !== 16'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_frame_bits: got %0d busy=%b expected 4 busy=0", nm, frame_bits, busy);
    end
    n_checks++;
    if (uns != 0) begin
      n_fail++;
      $display("FAIL %s_stable: got %0d unstable stalls expected 0", nm, uns);
    end
  endtask

  task automatic test_zero_frame();
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    int uns, gaps;
    bit to;
    for (int i = 0; i < 8; i++) begin
      b.push_back(1'b0);
      l.push_back(i == 7);
    end
    run_frame(b, l, 10, 0, 0, 1'b0, got, uns, gaps, to);
    n_checks++;
    if (to || got.size() != 10) begin
      n_fail++;
      $display("FAIL zero_count: got %0d pairs expected 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i] !== {i >= 8, 2'b00}) begin
        n_fail++;
        $display("FAIL zero_pair%0d: got %b expected %b", i, got[i], {i >= 8, 2'b00});
      end
    end
    n_checks++;
    if (frame_bits !== 16'd8) begin
      n_fail++;
      $display("FAIL zero_frame_bits: got %0d expected 8", frame_bits);
    end
  endtask

  task automatic test_refresh();
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    logic [2:0] ex[$];
    int uns, gaps;
    bit to;
    pair_ready = 1'b1;
    din_valid = 1'b1;
    din = 1'b1;
    din_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (din_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL refresh_pre_ready%0d: got %b expected 1", i, din_ready);
      end
      @(posedge clk);
      #1 din = 1'b0;
    end
    refresh = 1'b1;
    din = 1'b1;
    @(negedge clk);
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL refresh_blocks_din: got din_ready=%b expected 0", din_ready);
    end
    @(posedge clk);
    #1 refresh = 1'b0;
    din_valid = 1'b0;
    n_checks++;
    if (pair_valid !== 1'b0 || busy !== 1'b0 || frame_bits !== 16'd0 || bit_pair !== 2'b00) begin
      n_fail++;
      $display("FAIL refresh_clear: got v=%b busy=%b fb=%0d pair=%b expected 0 0 0 00",
               pair_valid, busy, frame_bits, bit_pair);
    end
    b = {1'b1};
    l = {1'b1};
    model(b, l, ex);
    run_frame(b, l, ex.size(), 0, 0, 1'b0, got, uns, gaps, to);
    n_checks++;
    if (to || got.size() != ex.size() || got[0] !== 3'b011) begin
      n_fail++;
      $display("FAIL refresh_restart: got %0d pairs first=%b expected %0d first=011",
               got.size(), got.size() > 0 ? got[0] : 3'bxxx, ex.size());
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    pair_ready = 1'b1;
    din_valid = 1'b1;
    din = 1'b1;
    din_last = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    din_last = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_in_tail: got busy=%b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bit_pair, pair_valid, pair_tail, busy, din_ready, frame_bits} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: got pair=%b v=%b t=%b busy=%b rdy=%b fb=%0d expected all 0",
               bit_pair, pair_valid, pair_tail, busy, din_ready, frame_bits);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pair_valid) seen++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_no_tail: got %0d pairs busy=%b expected 0 pairs busy=0", seen, busy);
    end
  endtask

  task automatic test_random();
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    logic [2:0] ex[$];
    int uns, gaps, n;
    bit to;
    for (int f = 0; f < 8; f++) begin
      n = (f == 0) ? 1 : $urandom_range(1, 12);
      b = {};
      l = {};
      for (int i = 0; i < n; i++) begin
        b.push_back(1'($urandom));
        l.push_back(i == n - 1);
      end
      model(b, l, ex);
      run_frame(b, l, ex.size(), 2, 1, 1'b0, got, uns, gaps, to);
      n_checks++;
      if (to || got != ex) begin
        n_fail++;
        $display("FAIL rand%0d_seq: got %0d pairs %p expected %0d pairs %p", f, got.size(), got,
                 ex.size(), ex);
      end
      n_checks++;
      if (frame_bits !== 16'(n) || uns != 0) begin
        n_fail++;
        $display("FAIL rand%0d_meta: got fb=%0d unstable=%0d expected fb=%0d unstable=0", f,
                 frame_bits, uns, n);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    logic [2:0] ex[$];
    int uns, gaps;
    bit to;
    int lens[3] = '{3, 1, 5};
    foreach (lens[f])
      for (int i = 0; i < lens[f]; i++) begin
        b.push_back(1'($urandom));
        l.push_back(i == lens[f] - 1);
      end
    model(b, l, ex);
    run_frame(b, l, ex.size(), 0, 0, 1'b0, got, uns, gaps, to);
    n_checks++;
    if (to || got != ex) begin
      n_fail++;
      $display("FAIL b2b_seq: got %p expected %p", got, ex);
    end
    n_checks++;
    if (gaps != 0 || frame_bits !== 16'd5) begin
      n_fail++;
      $display("FAIL b2b_bubbles: got gaps=%0d fb=%0d expected gaps=0 fb=5", gaps, frame_bits);
    end
  endtask

`ifdef ERR_INJECT_EN
  task automatic test_err_inject();
    bit b[$];
    bit l[$];
    logic [2:0] got[$];
    logic [2:0] ex[$];
    int uns, gaps;
    bit to;
    b = {1'b1, 1'b0, 1'b1, 1'b1};
    l = {1'b0, 1'b0, 1'b0, 1'b1};
    model(b, l, ex);
    ex[0] = ex[0] ^ 3'b010;
    err_mask = 2'b10;
    run_frame(b, l, ex.size(), 0, 0, 1'b1, got, uns, gaps, to);
    err_mask = 2'b00;
    n_checks++;
    if (to || got != ex) begin
      n_fail++;
      $display("FAIL err_inject_seq: got %p expected %p", got, ex);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_spec_frame(0, "frame1");
    test_zero_frame();
    test_spec_frame(1, "stall");
    test_refresh();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef ERR_INJECT_EN
    test_err_inject();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
